// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - circular reorder buffer: tag allocation, CDB capture, in-order retirement to the register file.
// Optional macro ROB_CDB_BYPASS_EN lets a CDB result for the head entry retire on the same edge it arrives.
module rob_commit #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = 4,
  parameter int NAME_W    = 5,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [NAME_W-1:0] alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              commit_en,
  output logic [NAME_W-1:0] commit_name,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag,
  output logic              rob_empty
);

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0] valid_q;
  logic [ROB_DEPTH-1:0] ready_q;
  logic [NAME_W-1:0]    dest_q [ROB_DEPTH];
  logic [DATA_W-1:0]    data_q [ROB_DEPTH];
  logic [TAG_W-1:0]     head;
  logic [TAG_W-1:0]     tail;
  logic [TAG_W:0]       count;

  logic              do_alloc;
  logic              cdb_write;
  logic              head_hit;
  logic              bypass;
  logic              do_commit;
  logic [DATA_W-1:0] head_data;

  // Full is judged on the pre-edge count, so a same-edge commit never frees a slot early.
  assign alloc_ready = (count != FULL_COUNT) && !flush;
  assign alloc_tag   = tail;
  assign rob_empty   = (count == '0);

  assign do_alloc  = alloc_valid && alloc_ready;
  assign cdb_write = cdb_valid && valid_q[cdb_tag] && !flush;
  assign head_hit  = valid_q[head] && ready_q[head];

`ifdef ROB_CDB_BYPASS_EN
  assign bypass = valid_q[head] && !ready_q[head] && cdb_valid && (cdb_tag == head);
`else
  assign bypass = 1'b0;
`endif

  assign do_commit = (head_hit || bypass) && !flush;
  assign head_data = bypass ? cdb_data : data_q[head];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q   <= '0;
      ready_q   <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      commit_en <= 1'b0;
      if (rst) begin
        commit_name <= '0;
        commit_data <= '0;
        commit_tag  <= '0;
      end
    end else begin
      if (do_alloc) begin
        valid_q[tail] <= 1'b1;
        ready_q[tail] <= 1'b0;
        tail          <= tail + 1'b1;
      end
      if (cdb_write) begin
        ready_q[cdb_tag] <= 1'b1;
      end
      commit_en <= 1'b0;
      if (do_commit) begin
        valid_q[head] <= 1'b0;
        head          <= head + 1'b1;
        // x0 frees its slot but never reaches the register file.
        commit_en     <= (dest_q[head] != '0);
        commit_name   <= dest_q[head];
        commit_data   <= head_data;
        commit_tag    <= head;
      end
      if (do_alloc && !do_commit) begin
        count <= count + 1'b1;
      end else if (!do_alloc && do_commit) begin
        count <= count - 1'b1;
      end
    end
  end

  // Payload needs no reset: valid/ready gate every use of it.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      dest_q[tail] <= alloc_dest;
    end
    if (cdb_write) begin
      data_q[cdb_tag] <= cdb_data;
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - directed self-checking bench for rob_commit.
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        rst, flush, alloc_valid, cdb_valid;
  logic [4:0]  alloc_dest;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        alloc_ready, commit_en, rob_empty;
  logic [3:0]  alloc_tag, commit_tag;
  logic [4:0]  commit_name;
  logic [31:0] commit_data;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rob_commit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_en(commit_en), .commit_name(commit_name),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .rob_empty(rob_empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; alloc_valid = 1'b0; alloc_dest = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    total++; if (rob_empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", rob_empty); else passed++;
    total++; if (alloc_ready !== 1'b1) $display("FAIL reset_alloc_ready got %b exp 1", alloc_ready); else passed++;
    total++; if (alloc_tag !== 4'd0) $display("FAIL reset_alloc_tag got %0d exp 0", alloc_tag); else passed++;
    total++; if (commit_en !== 1'b0) $display("FAIL reset_commit_en got %b exp 0", commit_en); else passed++;
    total++; if (commit_name !== 5'd0) $display("FAIL reset_commit_name got %0d exp 0", commit_name); else passed++;
    total++; if (commit_data !== 32'd0) $display("FAIL reset_commit_data got %h exp 0", commit_data); else passed++;
    total++; if (commit_tag !== 4'd0) $display("FAIL reset_commit_tag got %0d exp 0", commit_tag); else passed++;
  endtask

  task automatic test_alloc_order();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 5'(3 + i);
      #1;
      total++; if (alloc_tag !== 4'(i)) $display("FAIL alloc_tag_%0d got %0d exp %0d", i, alloc_tag, i); else passed++;
      total++; if (alloc_ready !== 1'b1) $display("FAIL alloc_ready_%0d got %b exp 1", i, alloc_ready); else passed++;
      tick();
    end
    idle();
    #1;
    total++; if (rob_empty !== 1'b0) $display("FAIL alloc_not_empty got %b exp 0", rob_empty); else passed++;
    total++; if (commit_en !== 1'b0) $display("FAIL alloc_no_commit got %b exp 0", commit_en); else passed++;
  endtask

  task automatic test_in_order_commit();
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_data = 32'hAA;
    tick();
    total++; if (commit_en !== 1'b0) $display("FAIL ooo_hold got %b exp 0", commit_en); else passed++;
    cdb_tag = 4'd0; cdb_data = 32'h55;
    tick();
    idle();
`ifndef ROB_CDB_BYPASS_EN
    total++; if (commit_en !== 1'b0) $display("FAIL head_ready_wait got %b exp 0", commit_en); else passed++;
    tick();
`endif
    total++; if (commit_en !== 1'b1) $display("FAIL c0_en got %b exp 1", commit_en); else passed++;
    total++; if (commit_name !== 5'd3 || commit_data !== 32'h55 || commit_tag !== 4'd0)
      $display("FAIL c0_fields got name %0d data %h tag %0d exp 3 55 0", commit_name, commit_data, commit_tag); else passed++;
    tick();
    total++; if (commit_en !== 1'b1) $display("FAIL c1_en got %b exp 1", commit_en); else passed++;
    total++; if (commit_name !== 5'd4 || commit_data !== 32'hAA || commit_tag !== 4'd1)
      $display("FAIL c1_fields got name %0d data %h tag %0d exp 4 aa 1", commit_name, commit_data, commit_tag); else passed++;
    tick();
    total++; if (commit_en !== 1'b0) $display("FAIL c2_not_ready got %b exp 0", commit_en); else passed++;
    total++; if (commit_name !== 5'd4 || commit_data !== 32'hAA)
      $display("FAIL commit_hold got name %0d data %h exp 4 aa", commit_name, commit_data); else passed++;
    do_flush();
    #1;
    total++; if (rob_empty !== 1'b1) $display("FAIL flush_clean got %b exp 1", rob_empty); else passed++;
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 16; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 5'(i + 1);
      tick();
    end
    alloc_dest = 5'd9;
    #1;
    total++; if (alloc_ready !== 1'b0) $display("FAIL full_ready got %b exp 0", alloc_ready); else passed++;
    tick();
    total++; if (alloc_ready !== 1'b0) $display("FAIL full_drop got %b exp 0", alloc_ready); else passed++;
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_data = 32'h11;
    tick();
    cdb_valid = 1'b0;
`ifndef ROB_CDB_BYPASS_EN
    #1;
    total++; if (alloc_ready !== 1'b0) $display("FAIL full_commit_same_edge got %b exp 0", alloc_ready); else passed++;
    tick();
`endif
    total++; if (commit_en !== 1'b1 || commit_tag !== 4'd0 || commit_name !== 5'd1 || commit_data !== 32'h11)
      $display("FAIL full_commit got en %b tag %0d name %0d data %h exp 1 0 1 11", commit_en, commit_tag, commit_name, commit_data); else passed++;
    total++; if (alloc_ready !== 1'b1 || alloc_tag !== 4'd0)
      $display("FAIL wrap_slot got ready %b tag %0d exp 1 0", alloc_ready, alloc_tag); else passed++;
    tick();
    idle();
    #1;
    total++; if (alloc_ready !== 1'b0 || alloc_tag !== 4'd1)
      $display("FAIL wrap_refill got ready %b tag %0d exp 0 1", alloc_ready, alloc_tag); else passed++;
    total++; if (commit_en !== 1'b0) $display("FAIL wrap_en_drop got %b exp 0", commit_en); else passed++;
    do_flush();
  endtask

  task automatic test_x0();
    alloc_valid = 1'b1; alloc_dest = 5'd0;
    tick();
    idle();
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_data = 32'h1234;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      total++; if (commit_en !== 1'b0) $display("FAIL x0_silent_%0d got %b exp 0", i, commit_en); else passed++;
      tick();
    end
    total++; if (rob_empty !== 1'b1) $display("FAIL x0_freed got %b exp 1", rob_empty); else passed++;
    total++; if (commit_data !== 32'h1234 || commit_tag !== 4'd0 || commit_name !== 5'd0)
      $display("FAIL x0_fields got data %h tag %0d name %0d exp 1234 0 0", commit_data, commit_tag, commit_name); else passed++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1; alloc_dest = 5'(10 + i);
      tick();
    end
    flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_data = 32'h77;
    alloc_dest = 5'd20;
    #1;
    total++; if (alloc_ready !== 1'b0) $display("FAIL flush_blocks_alloc got %b exp 0", alloc_ready); else passed++;
    tick();
    idle();
    #1;
    total++; if (rob_empty !== 1'b1) $display("FAIL flush_empty got %b exp 1", rob_empty); else passed++;
    total++; if (alloc_tag !== 4'd0 || alloc_ready !== 1'b1)
      $display("FAIL flush_tag got tag %0d ready %b exp 0 1", alloc_tag, alloc_ready); else passed++;
    total++; if (commit_en !== 1'b0) $display("FAIL flush_no_commit got %b exp 0", commit_en); else passed++;
    tick();
    total++; if (commit_en !== 1'b0) $display("FAIL flush_no_late_commit got %b exp 0", commit_en); else passed++;
  endtask

  task automatic test_latency();
    alloc_valid = 1'b1; alloc_dest = 5'd7;
    tick();
    idle();
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_data = 32'hBEEF;
    #1;
    total++; if (commit_en !== 1'b0) $display("FAIL lat_n got %b exp 0", commit_en); else passed++;
    tick();
    idle();
`ifdef ROB_CDB_BYPASS_EN
    total++; if (commit_en !== 1'b1) $display("FAIL lat_n1 got %b exp 1", commit_en); else passed++;
    total++; if (commit_data !== 32'hBEEF || commit_name !== 5'd7)
      $display("FAIL lat_fields got data %h name %0d exp beef 7", commit_data, commit_name); else passed++;
    tick();
    total++; if (commit_en !== 1'b0) $display("FAIL lat_n2 got %b exp 0", commit_en); else passed++;
`else
    total++; if (commit_en !== 1'b0) $display("FAIL lat_n1 got %b exp 0", commit_en); else passed++;
    tick();
    total++; if (commit_en !== 1'b1) $display("FAIL lat_n2 got %b exp 1", commit_en); else passed++;
    total++; if (commit_data !== 32'hBEEF || commit_name !== 5'd7 || commit_tag !== 4'd0)
      $display("FAIL lat_fields got data %h name %0d tag %0d exp beef 7 0", commit_data, commit_name, commit_tag); else passed++;
`endif
    tick();
    total++; if (rob_empty !== 1'b1) $display("FAIL lat_empty got %b exp 1", rob_empty); else passed++;
  endtask

  initial begin
    test_reset();
    test_alloc_order();
    test_in_order_commit();
    test_full_wrap();
    test_x0();
    test_flush();
    test_latency();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
